// File: rtl/spi_pkg.sv
// Shared definitions for the SPI main: command bytes, FSM encoding and the
// sensor register map used by the readout control logic.
package spi_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h0A;
    localparam logic [7:0] CMD_READ  = 8'h0B;

    localparam logic [7:0] XDATA_L   = 8'h0E;
    localparam logic [7:0] XDATA_H   = 8'h0F;
    localparam logic [7:0] YDATA_L   = 8'h10;
    localparam logic [7:0] YDATA_H   = 8'h11;
    localparam logic [7:0] ZDATA_L   = 8'h12;
    localparam logic [7:0] ZDATA_H   = 8'h13;
    localparam logic [7:0] TEMP_L    = 8'h14;
    localparam logic [7:0] TEMP_H    = 8'h15;
    localparam logic [7:0] POWER_CTL = 8'h2D;
    localparam logic [1:0] MEASURE_MODE = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        CS_GAP
    } state_t;

    function automatic logic [7:0] cmd_byte(input logic rd);
        return rd ? CMD_READ : CMD_WRITE;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SPI clock divider: toggles sclk every HALF_DIV cycles while enabled and
// flags the cycle in which each rising/falling edge is about to be launched.
module spi_clk_gen #(
    parameter int HALF_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int CW = $clog2(HALF_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;
    logic          tick;

    assign tick = en && (cnt_q == CW'(HALF_DIV - 1));

    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (!en) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else if (tick) begin
            cnt_d  = '0;
            sclk_d = ~sclk_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    // Strobes are asserted in the cycle whose closing edge moves sclk.
    assign sclk     = sclk_q;
    assign rise_stb = tick & ~sclk_q;
    assign fall_stb = tick &  sclk_q;

endmodule

// File: rtl/spi_main.sv
// Mode-0 SPI main issuing cmd/addr/data register transactions under a single
// cs_n assertion, with a byte-level request/response interface.
module spi_main
    import spi_pkg::*;
#(
    parameter int HALF_DIV = 4,
    parameter int NB_W     = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            rw,
    input  logic [7:0]      addr,
    input  logic [NB_W-1:0] nbytes,
    input  logic [7:0]      tx_data,
    output logic            tx_req,
    output logic [7:0]      rx_data,
    output logic            rx_valid,
    output logic            busy,
    output logic            done,
    output logic            sclk,
    output logic            mosi,
    input  logic            miso,
    output logic            cs_n
);

    localparam int CW  = $clog2(HALF_DIV);
    localparam int BCW = NB_W + 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(HALF_DIV - 1);
    localparam logic [BCW-1:0] HDR_BYTES = BCW'(2);

    state_t         state_q, state_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           cs_n_q, cs_n_d;
    logic           rw_q, rw_d;
    logic [7:0]     addr_q, addr_d;
    logic [BCW-1:0] total_q, total_d;
    logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     tx_sh_q, tx_sh_d;
    logic [6:0]     rx_sh_q, rx_sh_d;
    logic [7:0]     rx_data_q, rx_data_d;
    logic           rx_valid_q, rx_valid_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           tx_req_c;
    logic           clk_en, rise_stb, fall_stb;

    // Divider runs through CS_SETUP so its first toggle doubles as the setup time.
    assign clk_en = (state_q == CS_SETUP) || (state_q == SHIFT);

    spi_clk_gen #(.HALF_DIV(HALF_DIV)) u_clk_gen (
        .clk      (clk),
        .rst      (rst),
        .en       (clk_en),
        .sclk     (sclk),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cs_n_d     = cs_n_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        total_d    = total_q;
        byte_cnt_d = byte_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        cnt_d      = cnt_q;
        tx_req_c   = 1'b0;

        case (state_q)
            IDLE: begin
                // done_q marks the done cycle, in which start is still ignored.
                if (start && !done_q && (nbytes != '0)) begin
                    state_d    = CS_SETUP;
                    busy_d     = 1'b1;
                    cs_n_d     = 1'b0;
                    rw_d       = rw;
                    addr_d     = addr;
                    total_d    = BCW'(nbytes) + HDR_BYTES;
                    byte_cnt_d = '0;
                    bit_cnt_d  = '0;
                    tx_sh_d    = cmd_byte(rw);
                end
            end
            CS_SETUP, SHIFT: begin
                if (rise_stb) begin
                    state_d   = SHIFT;
                    rx_sh_d   = {rx_sh_q[5:0], miso};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        byte_cnt_d = byte_cnt_q + BCW'(1);
                        if (rw_q && (byte_cnt_q >= HDR_BYTES)) begin
                            rx_data_d  = {rx_sh_q, miso};
                            rx_valid_d = 1'b1;
                        end
                    end
                end
                if (fall_stb) begin
                    if (bit_cnt_q != 3'd0) begin
                        tx_sh_d = {tx_sh_q[6:0], 1'b0};
                    end else if (byte_cnt_q == total_q) begin
                        state_d = CS_HOLD;
                        cnt_d   = '0;
                    end else if (byte_cnt_q == BCW'(1)) begin
                        tx_sh_d = addr_q;
                    end else if (!rw_q) begin
                        tx_sh_d  = tx_data;
                        tx_req_c = 1'b1;
                    end else begin
                        tx_sh_d = 8'h00;
                    end
                end
            end
            CS_HOLD: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = CS_GAP;
                    cs_n_d  = 1'b1;
                    cnt_d   = '0;
                    tx_sh_d = 8'h00;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            CS_GAP: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            total_q    <= '0;
            byte_cnt_q <= '0;
            bit_cnt_q  <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cs_n_q     <= cs_n_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            total_q    <= total_d;
            byte_cnt_q <= byte_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            cnt_q      <= cnt_d;
        end
    end

    assign tx_req   = tx_req_c;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign mosi     = tx_sh_q[7];
    assign cs_n     = cs_n_q;

endmodule

// File: tb/tb_spi_main.sv
// Self-checking bench for spi_main: Mode-0 secondary model, event logs and a
// transaction-level reference for the expected serial stream and timing.
module tb_spi_main;

    localparam int H    = 4;
    localparam int NBW  = 6;
    localparam int LOGN = 8192;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           rw = 1'b0;
    logic [7:0]     addr = 8'h00;
    logic [NBW-1:0] nbytes = '0;
    logic [7:0]     tx_data;
    logic           tx_req, rx_valid, busy, done, sclk, mosi, cs_n;
    logic [7:0]     rx_data;
    logic           miso = 1'b0;

    spi_main #(.HALF_DIV(H), .NB_W(NBW)) dut (
        .clk(clk), .rst(rst), .start(start), .rw(rw), .addr(addr),
        .nbytes(nbytes), .tx_data(tx_data), .tx_req(tx_req),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done),
        .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;

    // Free-running event logs; tests snapshot the *_base indices.
    logic       mosi_log [0:LOGN-1];
    int         rise_cyc [0:LOGN-1];
    int         csf_cyc  [0:255];
    int         done_cyc [0:255];
    logic [7:0] rx_log   [0:255];
    int rise_tot = 0, csf_tot = 0, done_tot = 0, rx_tot = 0, txr_tot = 0, widx = 0;
    int rise_base = 0, csf_base = 0, done_base = 0, rx_base = 0, txr_base = 0, wbase = 0;
    bit adv = 1'b0;
    logic sclk_prev = 1'b0, cs_n_prev = 1'b1;
    int sec_idx;
    logic [7:0] sec_cur;

    logic [7:0] wbuf      [0:63];
    logic [7:0] sec_bytes [0:63];
    int  start_edge;
    bit  timed_out;

    assign tx_data = wbuf[6'(widx - wbase)];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (adv) begin
            widx = widx + 1;
            adv  = 1'b0;
        end
        if (tx_req === 1'b1) begin
            txr_tot = txr_tot + 1;
            adv     = 1'b1;
        end
        if (sclk === 1'b1 && sclk_prev === 1'b0) begin
            mosi_log[rise_tot % LOGN] = mosi;
            rise_cyc[rise_tot % LOGN] = cyc;
            rise_tot = rise_tot + 1;
        end
        // Secondary launches the next bit after each sclk fall and at cs_n fall.
        if ((sclk === 1'b0 && sclk_prev === 1'b1) || (cs_n === 1'b0 && cs_n_prev === 1'b1)) begin
            sec_idx = rise_tot - rise_base;
            sec_cur = sec_bytes[(sec_idx >> 3) & 63];
            miso    = sec_cur[3'(7 - (sec_idx & 7))];
        end
        if (cs_n === 1'b0 && cs_n_prev === 1'b1) begin
            csf_cyc[csf_tot % 256] = cyc;
            csf_tot = csf_tot + 1;
        end
        if (done === 1'b1) begin
            done_cyc[done_tot % 256] = cyc;
            done_tot = done_tot + 1;
        end
        if (rx_valid === 1'b1) begin
            rx_log[rx_tot % 256] = rx_data;
            rx_tot = rx_tot + 1;
        end
        sclk_prev = sclk;
        cs_n_prev = cs_n;
    end

    function automatic logic [7:0] obs_byte(input int k);
        logic [7:0] v = 8'h00;
        for (int j = 0; j < 8; j++) v = {v[6:0], mosi_log[(rise_base + 8*k + j) % LOGN]};
        return v;
    endfunction

    function automatic logic [7:0] exp_byte(input logic r, input logic [7:0] a, input int k);
        if (k == 0) return r ? 8'h0B : 8'h0A;
        if (k == 1) return a;
        return r ? 8'h00 : wbuf[k-2];
    endfunction

    task automatic snap_bases();
        rise_base = rise_tot; csf_base = csf_tot; done_base = done_tot;
        rx_base = rx_tot; txr_base = txr_tot; wbase = widx;
    endtask

    // Drives one transaction and waits for done; poke=1 also fires start while busy and in the done cycle.
    task automatic run_txn(input logic r, input logic [7:0] a, input int n, input int poke);
        int limit;
        @(negedge clk);
        snap_bases();
        sec_bytes[0] = 8'($urandom);
        sec_bytes[1] = 8'($urandom);
        start = 1'b1; rw = r; addr = a; nbytes = NBW'(n);
        @(negedge clk);
        start = 1'b0; start_edge = cyc;
        rw = ~r; addr = 8'($urandom); nbytes = NBW'($urandom);
        timed_out = 1'b1;
        limit = 16*H*(n+2) + 16*H;
        for (int i = 0; i < limit; i++) begin
            if (poke == 1) begin
                start = (i == 20);
                if (i == 20) begin rw = ~r; addr = 8'hA5; nbytes = NBW'(3); end
            end
            @(negedge clk);
            if (done === 1'b1) begin timed_out = 1'b0; break; end
        end
        if (poke == 1 && !timed_out) begin
            start = 1'b1; nbytes = NBW'(4);
            @(negedge clk);
            start = 1'b0;
        end
        start = 1'b0;
        repeat (3*H) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++; if (cs_n !== 1'b1) begin n_fail++; $display("FAIL reset_cs_n: got %b expected 1", cs_n); end
        n_tests++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
        n_tests++; if (mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b expected 0", mosi); end
        n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done: got %b%b expected 00", busy, done); end
        n_tests++; if (tx_req !== 1'b0 || rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got %b%b expected 00", tx_req, rx_valid); end
        n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++; if (cs_n !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got cs_n=%b busy=%b expected 1/0", cs_n, busy); end
    endtask

    task automatic test_write_power_ctl();
        logic [7:0] e [0:2];
        e[0] = 8'h0A; e[1] = 8'h2D; e[2] = 8'h02;
        wbuf[0] = 8'h02;
        run_txn(1'b0, 8'h2D, 1, 0);
        n_tests++; if (timed_out) begin n_fail++; $display("FAIL wr1_timeout: got no done expected done"); end
        n_tests++; if (rise_tot - rise_base != 24) begin n_fail++; $display("FAIL wr1_rises: got %0d expected 24", rise_tot - rise_base); end
        for (int k = 0; k < 3; k++) begin
            n_tests++; if (obs_byte(k) !== e[k]) begin n_fail++; $display("FAIL wr1_mosi_byte%0d: got %h expected %h", k, obs_byte(k), e[k]); end
        end
        n_tests++; if (txr_tot - txr_base != 1) begin n_fail++; $display("FAIL wr1_tx_req: got %0d expected 1", txr_tot - txr_base); end
        n_tests++; if (done_tot - done_base != 1) begin n_fail++; $display("FAIL wr1_done: got %0d expected 1", done_tot - done_base); end
        n_tests++; if (cs_n !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL wr1_idle_after: got cs_n=%b busy=%b expected 1/0", cs_n, busy); end
        n_tests++; if (rise_cyc[(rise_base+1) % LOGN] - rise_cyc[rise_base % LOGN] != 2*H) begin
            n_fail++; $display("FAIL wr1_sclk_period: got %0d expected %0d", rise_cyc[(rise_base+1) % LOGN] - rise_cyc[rise_base % LOGN], 2*H);
        end
    endtask

    task automatic test_read_burst();
        sec_bytes[2] = 8'hDE; sec_bytes[3] = 8'hAD;
        run_txn(1'b1, 8'h0E, 2, 0);
        n_tests++; if (timed_out) begin n_fail++; $display("FAIL rd2_timeout: got no done expected done"); end
        n_tests++; if (rise_tot - rise_base != 32) begin n_fail++; $display("FAIL rd2_rises: got %0d expected 32", rise_tot - rise_base); end
        n_tests++; if (obs_byte(0) !== 8'h0B || obs_byte(1) !== 8'h0E) begin n_fail++; $display("FAIL rd2_hdr: got %h %h expected 0b 0e", obs_byte(0), obs_byte(1)); end
        n_tests++; if (obs_byte(2) !== 8'h00 || obs_byte(3) !== 8'h00) begin n_fail++; $display("FAIL rd2_mosi_data: got %h %h expected 00 00", obs_byte(2), obs_byte(3)); end
        n_tests++; if (rx_tot - rx_base != 2) begin n_fail++; $display("FAIL rd2_rx_count: got %0d expected 2", rx_tot - rx_base); end
        n_tests++; if (rx_log[rx_base % 256] !== 8'hDE) begin n_fail++; $display("FAIL rd2_rx0: got %h expected de", rx_log[rx_base % 256]); end
        n_tests++; if (rx_log[(rx_base+1) % 256] !== 8'hAD) begin n_fail++; $display("FAIL rd2_rx1: got %h expected ad", rx_log[(rx_base+1) % 256]); end
        n_tests++; if (rx_data !== 8'hAD) begin n_fail++; $display("FAIL rd2_rx_hold: got %h expected ad", rx_data); end
        n_tests++; if (txr_tot - txr_base != 0) begin n_fail++; $display("FAIL rd2_tx_req: got %0d expected 0", txr_tot - txr_base); end
    endtask

    task automatic test_timing();
        int last;
        wbuf[0] = 8'h5C;
        run_txn(1'b0, 8'h2D, 1, 0);
        last = rise_cyc[(rise_tot - 1) % LOGN];
        n_tests++; if (csf_cyc[csf_base % 256] != start_edge) begin n_fail++; $display("FAIL tim_cs_fall: got %0d expected %0d", csf_cyc[csf_base % 256], start_edge); end
        n_tests++; if (rise_cyc[rise_base % LOGN] != start_edge + H) begin n_fail++; $display("FAIL tim_first_rise: got %0d expected %0d", rise_cyc[rise_base % LOGN], start_edge + H); end
        n_tests++; if (done_cyc[done_base % 256] != last + 3*H) begin n_fail++; $display("FAIL tim_done: got %0d expected %0d", done_cyc[done_base % 256], last + 3*H); end
    endtask

    task automatic test_burst_write();
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
        run_txn(1'b0, 8'h20, 3, 0);
        n_tests++; if (txr_tot - txr_base != 3) begin n_fail++; $display("FAIL bw_tx_req: got %0d expected 3", txr_tot - txr_base); end
        for (int k = 0; k < 5; k++) begin
            n_tests++; if (obs_byte(k) !== exp_byte(1'b0, 8'h20, k)) begin n_fail++; $display("FAIL bw_byte%0d: got %h expected %h", k, obs_byte(k), exp_byte(1'b0, 8'h20, k)); end
        end
    endtask

    task automatic test_ignored_starts();
        snap_bases();
        @(negedge clk);
        start = 1'b1; rw = 1'b1; addr = 8'h0E; nbytes = '0;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        n_tests++; if (csf_tot - csf_base != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL nb0_ignored: got cs_falls=%0d busy=%b expected 0/0", csf_tot - csf_base, busy); end
        n_tests++; if (done_tot - done_base != 0) begin n_fail++; $display("FAIL nb0_done: got %0d expected 0", done_tot - done_base); end
        wbuf[0] = 8'h5A; wbuf[1] = 8'hC3;
        run_txn(1'b0, 8'h1F, 2, 1);
        n_tests++; if (csf_tot - csf_base != 1) begin n_fail++; $display("FAIL busy_start_cs: got %0d expected 1", csf_tot - csf_base); end
        n_tests++; if (done_tot - done_base != 1) begin n_fail++; $display("FAIL busy_start_done: got %0d expected 1", done_tot - done_base); end
        n_tests++; if (rise_tot - rise_base != 32) begin n_fail++; $display("FAIL busy_start_rises: got %0d expected 32", rise_tot - rise_base); end
        for (int k = 0; k < 4; k++) begin
            n_tests++; if (obs_byte(k) !== exp_byte(1'b0, 8'h1F, k)) begin n_fail++; $display("FAIL busy_start_byte%0d: got %h expected %h", k, obs_byte(k), exp_byte(1'b0, 8'h1F, k)); end
        end
    endtask

    task automatic test_reset_mid();
        bit reached = 1'b0;
        wbuf[0] = 8'h77; wbuf[1] = 8'h88;
        @(negedge clk);
        snap_bases();
        start = 1'b1; rw = 1'b0; addr = 8'h2D; nbytes = NBW'(2);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40*H; i++) begin
            @(negedge clk);
            if (rise_tot - rise_base >= 12) begin reached = 1'b1; break; end
        end
        n_tests++; if (!reached) begin n_fail++; $display("FAIL rmid_reach: got %0d rises expected 12", rise_tot - rise_base); end
        rst = 1'b1;
        #1;
        n_tests++; if (cs_n !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_immediate: got cs_n=%b sclk=%b busy=%b expected 1/0/0", cs_n, sclk, busy); end
        @(negedge clk);
        rst = 1'b0;
        repeat (40*H) @(negedge clk);
        n_tests++; if (done_tot - done_base != 0) begin n_fail++; $display("FAIL rmid_no_done: got %0d expected 0", done_tot - done_base); end
        n_tests++; if (txr_tot - txr_base != 0) begin n_fail++; $display("FAIL rmid_no_tx_req: got %0d expected 0", txr_tot - txr_base); end
        n_tests++; if (csf_tot - csf_base != 1 || cs_n !== 1'b1) begin n_fail++; $display("FAIL rmid_cs: got falls=%0d cs_n=%b expected 1/1", csf_tot - csf_base, cs_n); end
        wbuf[0] = 8'h02;
        run_txn(1'b0, 8'h2D, 1, 0);
        n_tests++; if (timed_out || done_tot - done_base != 1) begin n_fail++; $display("FAIL rmid_clean_done: got %0d expected 1", done_tot - done_base); end
        for (int k = 0; k < 3; k++) begin
            n_tests++; if (obs_byte(k) !== exp_byte(1'b0, 8'h2D, k)) begin n_fail++; $display("FAIL rmid_clean_byte%0d: got %h expected %h", k, obs_byte(k), exp_byte(1'b0, 8'h2D, k)); end
        end
    endtask

    task automatic test_random();
        logic r;
        logic [7:0] a;
        int n;
        for (int t = 0; t < 6; t++) begin
            r = 1'($urandom_range(0, 1));
            a = 8'($urandom);
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                wbuf[i] = 8'($urandom);
                sec_bytes[i+2] = 8'($urandom);
            end
            run_txn(r, a, n, 0);
            n_tests++; if (timed_out || done_tot - done_base != 1) begin n_fail++; $display("FAIL rnd%0d_done: got %0d expected 1", t, done_tot - done_base); end
            n_tests++; if (rise_tot - rise_base != 8*(n+2)) begin n_fail++; $display("FAIL rnd%0d_rises: got %0d expected %0d", t, rise_tot - rise_base, 8*(n+2)); end
            for (int k = 0; k < n+2; k++) begin
                n_tests++; if (obs_byte(k) !== exp_byte(r, a, k)) begin n_fail++; $display("FAIL rnd%0d_byte%0d: got %h expected %h", t, k, obs_byte(k), exp_byte(r, a, k)); end
            end
            n_tests++; if (txr_tot - txr_base != (r ? 0 : n)) begin n_fail++; $display("FAIL rnd%0d_tx_req: got %0d expected %0d", t, txr_tot - txr_base, r ? 0 : n); end
            n_tests++; if (rx_tot - rx_base != (r ? n : 0)) begin n_fail++; $display("FAIL rnd%0d_rx_count: got %0d expected %0d", t, rx_tot - rx_base, r ? n : 0); end
            if (r) begin
                for (int j = 0; j < n; j++) begin
                    n_tests++; if (rx_log[(rx_base+j) % 256] !== sec_bytes[j+2]) begin n_fail++; $display("FAIL rnd%0d_rx%0d: got %h expected %h", t, j, rx_log[(rx_base+j) % 256], sec_bytes[j+2]); end
                end
            end
            n_tests++; if (done_cyc[done_base % 256] != rise_cyc[(rise_tot-1) % LOGN] + 3*H) begin
                n_fail++; $display("FAIL rnd%0d_done_time: got %0d expected %0d", t, done_cyc[done_base % 256], rise_cyc[(rise_tot-1) % LOGN] + 3*H);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin wbuf[i] = 8'h00; sec_bytes[i] = 8'h00; end
        test_reset();
        test_write_power_ctl();
        test_read_burst();
        test_timing();
        test_burst_write();
        test_ignored_starts();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
